// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// counter sizing.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of a counter that counts 0..w-1. It is never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit combinational full subtractor: diff = a - b - c, with the borrow
// returned on bo.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic diff,
   output logic bo
);

   assign diff = a ^ b ^ c;
   assign bo   = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor. It processes one bit per clock, LSB first,
// and reports unsigned less-than (bout) and equality (eq) when it completes.
module serial_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             eq
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sa_reg, sb_reg, sd_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;

   logic             d, bo;
   logic             accept, last;
   logic [WIDTH-1:0] sd_next;

   fs_cell u_cell (
      .a    (sa_reg[0]),
      .b    (sb_reg[0]),
      .c    (br_reg),
      .diff (d),
      .bo   (bo)
   );

   assign accept  = start && (state_reg != RUN);
   assign last    = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
   assign sd_next = {d, sd_reg[WIDTH-1:1]};

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         sd_reg    <= '0;
         br_reg    <= 1'b0;
         cnt_reg   <= '0;
         diff      <= '0;
         bout      <= 1'b0;
         eq        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            sa_reg  <= a;
            sb_reg  <= b;
            br_reg  <= bin;
            cnt_reg <= '0;
         end else if (state_reg == RUN) begin
            sa_reg  <= sa_reg >> 1;
            sb_reg  <= sb_reg >> 1;
            sd_reg  <= sd_next;
            br_reg  <= bo;
            // The counter stops at WIDTH-1. The next accept clears it.
            if (!last) cnt_reg <= cnt_reg + CW'(1);
            // Result registers load only on the final bit, so they hold during RUN.
            if (last) begin
               diff <= sd_next;
               bout <= bo;
               eq   <= (sd_next == '0) && !bo;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub. It runs an 8-bit instance through the handshake
// scenarios and a 2-bit instance through every operand combination.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8, eq8;
   logic [7:0] diff8;

   logic       start2 = 1'b0, bin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, bout2, eq2;
   logic [1:0] diff2;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .eq(eq8)
   );

   serial_sub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
      .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .eq(eq2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one operation, then count edges until done and the busy cycles seen.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic ee);
      int edges, busy_cycles;
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      busy_cycles = busy8 ? 1 : 0;
      edges = 0;
      while (edges < 20) begin
         tick();
         edges++;
         if (done8) break;
         busy_cycles += busy8 ? 1 : 0;
      end
      $display("op8 %02h - %02h - %0d -> diff=%02h bout=%0d eq=%0d after %0d edges",
               a, b, bin, diff8, bout8, eq8, edges);
      check("latency8", edges, 8);
      check("busy_cycles8", busy_cycles, 8);
      check("diff8", diff8, ed);
      check("bout8", bout8, eb);
      check("eq8", eq8, ee);
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic bin);
      int edges;
      logic [2:0] g;
      g = {1'b0, a} - {1'b0, b} - {2'b00, bin};
      a2 = a; b2 = b; bin2 = bin; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      edges = 0;
      while (edges < 10) begin
         tick();
         edges++;
         if (done2) break;
      end
      $display("op2 %0d - %0d - %0d -> diff=%0d bout=%0d eq=%0d", a, b, bin, diff2, bout2, eq2);
      check("latency2", edges, 2);
      check("diff2", diff2, g[1:0]);
      check("bout2", bout2, g[2]);
      check("eq2", eq2, (g == 3'd0));
   endtask

   initial begin
      int seen;
      #22;
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_diff", diff8, 0);
      check("rst_bout", bout8, 0);
      check("rst_eq", eq8, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Basic subtraction, the borrow case and the chained borrow-in case.
      run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1);

      // Back-to-back with start held. Operands are scrambled while RUN is in progress.
      a8 = 8'h77; b8 = 8'h77; bin8 = 1'b0; start8 = 1'b1;
      tick();                                   // t0
      for (int t = 1; t <= 8; t++) begin
         if (t < 8) begin a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
         tick();
         if (t < 8) check("b2b_busy", busy8, 1);
         if (t == 7) check("b2b_hold", diff8, 8'h00);
      end
      check("b2b_done1", done8, 1);               // t8
      check("b2b_diff1", diff8, 8'h00);
      check("b2b_eq1", eq8, 1);
      $display("b2b first result diff=%02h eq=%0d", diff8, eq8);
      a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
      tick();                                   // t9: second accept
      start8 = 1'b0;
      check("b2b_busy2", busy8, 1);
      for (int t = 10; t <= 17; t++) begin
         if (t < 17) begin a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
         tick();
         if (t < 17) check("b2b_nodone", done8, 0);
      end
      check("b2b_done2", done8, 1);               // t17
      check("b2b_diff2", diff8, 8'hFF);
      check("b2b_bout2", bout8, 1);
      $display("b2b second result diff=%02h bout=%0d", diff8, bout8);
      tick();
      check("b2b_idle", busy8 | done8, 0);

      // A start pulse at t3 is ignored, so only one done follows.
      a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
      tick();                                   // t0
      start8 = 1'b0;
      seen = 0;
      for (int t = 1; t <= 20; t++) begin
         start8 = (t == 3);
         tick();
         start8 = 1'b0;
         if (done8) begin
            seen++;
            check("ign_done_time", t, 8);
         end
      end
      check("ign_done_count", seen, 1);
      check("ign_diff", diff8, 8'h1E);
      $display("start-in-run: %0d done pulses", seen);

      // An asynchronous reset in mid-operation clears the outputs at once.
      a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (4) tick();
      #1 rst = 1'b1;
      #1;
      check("arst_busy", busy8, 0);
      check("arst_done", done8, 0);
      check("arst_diff", diff8, 0);
      check("arst_bout", bout8, 0);
      check("arst_eq", eq8, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (done8 || busy8) seen++;
      end
      check("arst_quiet", seen, 0);
      $display("reset mid-run: outputs cleared, no activity afterwards");
      run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

      // Every operand combination on the 2-bit instance.
      for (int i = 0; i < 32; i++)
         run2(2'(i >> 3), 2'(i >> 1), 1'(i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
